// File: rtl/snake_seg_monitor_if.sv
// Pin-side bundle of the snake segment monitor: sampled display lines in,
// tracking status and counters out.
interface snake_seg_monitor_if #(
  parameter int CNT_W = 8
);
  logic [6:0]       seg_in;
  logic             dp_in;
  logic             clr;
  logic [2:0]       head;
  logic             head_valid;
  logic             dir;
  logic             move;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] move_cnt;
  logic [3:0]       dp_cnt;

  modport master (
    output seg_in, dp_in, clr,
    input  head, head_valid, dir, move, err, err_code, move_cnt, dp_cnt
  );

  modport slave (
    input  seg_in, dp_in, clr,
    output head, head_valid, dir, move, err, err_code, move_cnt, dp_cnt
  );
endinterface

// File: rtl/snake_seg_monitor.sv
// Receive-side checker for the 7-segment snake: synchronizes and debounces the
// segment lines, then tracks the snake head and flags each step legal or not.
module snake_seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  snake_seg_monitor_if.slave  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NOHEAD = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  logic [6:0] seg_s1, seg_s2;
  logic       dp_s1, dp_s2, dp_s3;
  logic [3:0] stab_cnt, stab_next;
  logic       accept_now, accept_q;
  logic [6:0] acc_pat;
  logic [3:0] dp_cnt_q;

  state_t           state_q, state_next;
  logic [6:0]       ref_q, ref_next;
  logic [2:0]       head_q, head_next;
  logic             hv_q, hv_next;
  logic             dir_q, dir_next;
  logic             err_q, err_next;
  logic [1:0]       code_q, code_next;
  logic             move_q, move_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;

  function automatic logic [2:0] seg_idx(input logic [6:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [6:0] adj_mask(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b0100010;
      3'd1:    return 7'b1000101;
      3'd2:    return 7'b1001010;
      3'd3:    return 7'b0010100;
      3'd4:    return 7'b1101000;
      3'd5:    return 7'b1010001;
      3'd6:    return 7'b0110110;
      default: return 7'b0000000;
    endcase
  endfunction

  // seg_s1 is the value seg_s2 takes next, so the count covers the sample
  // being registered this edge; acceptance lands on the STABLE_CYCLES-th one.
  always_comb begin
    if (seg_s1 != seg_s2)    stab_next = 4'd1;
    else if (stab_cnt == STB) stab_next = stab_cnt;
    else                     stab_next = stab_cnt + 4'd1;
  end

  assign accept_now = (stab_next == STB) && (stab_cnt != STB) && (seg_s1 != ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      dp_s1    <= 1'b0;
      dp_s2    <= 1'b0;
      dp_s3    <= 1'b0;
      stab_cnt <= '0;
      accept_q <= 1'b0;
      acc_pat  <= '0;
      dp_cnt_q <= '0;
    end else begin
      seg_s1 <= bus.seg_in;
      seg_s2 <= seg_s1;
      dp_s1  <= bus.dp_in;
      dp_s2  <= dp_s1;
      dp_s3  <= dp_s2;
      if (bus.clr) begin
        stab_cnt <= '0;
        accept_q <= 1'b0;
        dp_cnt_q <= '0;
      end else begin
        stab_cnt <= stab_next;
        accept_q <= accept_now;
        if (accept_now) acc_pat <= seg_s1;
        if (dp_s2 && !dp_s3) dp_cnt_q <= dp_cnt_q + 4'd1;
      end
    end
  end

  logic [6:0] added;
  logic [2:0] new_idx;
  logic [6:0] adj_row;
  logic [2:0] ring_inc, ring_dec;
  int         pop_pat, pop_add;

  always_comb begin
    added    = acc_pat & ~ref_q;
    new_idx  = seg_idx(added);
    adj_row  = adj_mask(head_q);
    pop_pat  = $countones(acc_pat);
    pop_add  = $countones(added);
    ring_inc = (head_q == 3'd5) ? 3'd0 : head_q + 3'd1;
    ring_dec = (head_q == 3'd0) ? 3'd5 : head_q - 3'd1;
  end

  always_comb begin
    state_next = state_q;
    ref_next   = ref_q;
    head_next  = head_q;
    hv_next    = hv_q;
    dir_next   = dir_q;
    err_next   = err_q;
    code_next  = code_q;
    move_next  = 1'b0;
    cnt_next   = cnt_q;
    if (bus.clr) begin
      state_next = ST_INIT;
      ref_next   = '0;
      hv_next    = 1'b0;
      err_next   = 1'b0;
      code_next  = 2'd0;
      cnt_next   = '0;
    end else if (accept_q) begin
      // Every accepted pattern becomes the filter reference so a held bad
      // pattern is judged once, not re-flagged.
      ref_next = acc_pat;
      if (pop_pat != 3) begin
        err_next   = 1'b1;
        code_next  = 2'd1;
        state_next = ST_INIT;
        hv_next    = 1'b0;
      end else if (state_q == ST_INIT) begin
        state_next = ST_NOHEAD;
      end else if (pop_add != 1) begin
        err_next   = 1'b1;
        code_next  = 2'd2;
        state_next = ST_INIT;
        hv_next    = 1'b0;
      end else if (state_q == ST_TRACK && !adj_row[new_idx]) begin
        err_next   = 1'b1;
        code_next  = 2'd3;
        state_next = ST_NOHEAD;
        hv_next    = 1'b0;
      end else begin
        head_next  = new_idx;
        hv_next    = 1'b1;
        state_next = ST_TRACK;
        move_next  = 1'b1;
        cnt_next   = cnt_q + 1'b1;
        // Moves touching g carry no ring direction.
        if (state_q == ST_TRACK && head_q < 3'd6 && new_idx < 3'd6) begin
          if (new_idx == ring_inc)      dir_next = 1'b0;
          else if (new_idx == ring_dec) dir_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ref_q   <= '0;
      head_q  <= '0;
      hv_q    <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      move_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      ref_q   <= ref_next;
      head_q  <= head_next;
      hv_q    <= hv_next;
      dir_q   <= dir_next;
      err_q   <= err_next;
      code_q  <= code_next;
      move_q  <= move_next;
      cnt_q   <= cnt_next;
    end
  end

  assign bus.head       = head_q;
  assign bus.head_valid = hv_q;
  assign bus.dir        = dir_q;
  assign bus.move       = move_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign bus.move_cnt   = cnt_q;
  assign bus.dp_cnt     = dp_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/snake_seg_monitor.md
# snake_seg_monitor

Receive-side checker for the 7-segment snake animation. It samples the seven segment lines and the decimal point, as driven by the snake generator or read back from a display board. It filters glitches and tracks the snake head and direction. Each accepted animation step is flagged as a legal move or an error. It sits on the input pins of a companion tile, or in the bench as a self-checking monitor.

## Interface
Parameters:
- STABLE_CYCLES, 4: number of consecutive equal synchronized samples needed to accept a pattern (range 2..15).
- CNT_W, 8: width of the move counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- seg_in  input  7  segments a..g on bits 0..6, active high, asynchronous to clk.
- dp_in  input  1  decimal point, active high, asynchronous.
- clr  input  1  synchronous clear of err, counters and tracking state.
- head  output  3  current head segment index 0..6.
- head_valid  output  1  head is known.
- dir  output  1  0 = clockwise, 1 = counter-clockwise.
- move  output  1  one-cycle pulse per accepted legal move.
- err  output  1  sticky error flag.
- err_code  output  2  code of the most recent error.
- move_cnt  output  CNT_W  number of legal moves.
- dp_cnt  output  4  number of dp rising edges.

## Operation
- **Synchronizer:** seg_in and dp_in each pass through two flops; the second-stage value is called s2.
- **Glitch filter:**
  - A stability counter holds how long s2[6:0] has kept the same value.
  - The pattern is accepted on the cycle the counter reaches STABLE_CYCLES, and only if it differs from the stored reference pattern.
  - The counter saturates, so a held pattern is accepted once only.
- **Adjacency set:** a-b, b-c, c-d, d-e, e-f, f-a, g-b, g-c, g-e, g-f. All other segment pairs are non-adjacent.
- **Ring order for direction:** a, b, c, d, e, f (indices 0..5, wrapping).
- **State machine:**
  - INIT: no reference pattern. An accepted pattern with popcount 3 becomes the reference and the state goes to NOHEAD. Any other popcount raises error code 1 and the state stays INIT.
  - NOHEAD: an accepted pattern with popcount 3 that differs from the reference by exactly one segment removed and one added is a legal move. head becomes the added segment, head_valid goes to 1, and the state goes to TRACK.
  - TRACK: same test as NOHEAD, plus the added segment must be adjacent to head.
- **Errors (all priorities in this order):**
  - Popcount not 3: code 1; state goes to INIT; head_valid cleared.
  - Popcount 3 but more than one segment swapped: code 2; state goes to INIT; head_valid cleared.
  - Single swap but non-adjacent (TRACK only): code 3; reference updated; head_valid cleared; state goes to NOHEAD.
- **On every error:** err is set and err_code is updated. move is not pulsed and move_cnt is unchanged.
- **On a legal move:**
  - The reference pattern updates.
  - move pulses and move_cnt increments, wrapping at 2^CNT_W.
  - dir is updated only in TRACK, and only when both the old and new head are in the ring: 0 if new = old+1 mod 6, 1 if new = old-1 mod 6.
  - Moves into or out of g leave dir unchanged.
- **dp_cnt:** increments on each 0→1 edge of synchronized dp (no glitch filter) and wraps at 16.
- **clr:**
  - Zeroes err, err_code, move_cnt and dp_cnt, clears head_valid, and returns the state to INIT.
  - The stability counter restarts.
  - clr wins over an acceptance in the same cycle.
- **Reset values:** head=0, head_valid=0, dir=0, move=0, err=0, err_code=0, move_cnt=0, dp_cnt=0, state INIT, all synchronizer flops 0.

## Timing
- Let edge k be the first clock edge at which the first synchronizer flop captures a new seg_in value.
- s2 shows the new value after edge k+1.
- Acceptance is evaluated at edge k+STABLE_CYCLES. With the default of 4, that is edge k+4, counting the k+1 sample as the first of the four.
- head, dir, err, err_code and move_cnt are registered at edge k+STABLE_CYCLES+1.
- move is high for exactly the one cycle that follows edge k+STABLE_CYCLES+1.
- A pattern that holds for fewer than STABLE_CYCLES s2 samples is never accepted.
- dp_cnt updates at edge k+2 after a dp rise.
- Asserting rst_n low mid-filter forces all outputs to their reset values immediately. No move pulse is produced after rst_n is released.

## Test plan
- **Reset:** hold rst_n low, then apply seg_in=0x31 → all outputs at reset values. After STABLE_CYCLES+3 cycles: state NOHEAD, move=0, err=0.
- **Legal clockwise track:** 0x31 → 0x23 → 0x07.
  - After 0x23: head=1, head_valid=1, move_cnt=1.
  - After 0x07: head=2, dir=0, move_cnt=2.
  - move pulses once per step, exactly STABLE_CYCLES+1 cycles after edge k.
- **Counter-clockwise:** 0x31 → 0x38 → 0x1C.
  - After 0x38: head=3.
  - After 0x1C: head=2, dir=1, move_cnt=2.
- **Glitch rejection:** in TRACK at 0x07, drive 0x0B for STABLE_CYCLES-1 s2 samples, then return to 0x07 → no move, no err, head=2.
- **Errors:**
  - 0x07 → 0x0F: err=1, err_code=1, head_valid=0.
  - clr, then 0x31 → 0x23 → 0x07 → 0x16: err_code=3, head_valid=0, move_cnt=2.
  - 0x07 → 0x38: err_code=2.
- **Counters:**
  - 5 dp pulses of 3 cycles each → dp_cnt=5.
  - 2^CNT_W+1 legal moves → move_cnt=1.
  - rst_n pulsed low during the stability window → no move, all zeros.
